m216_ff6: RTL
=============

// Module: m216_ff6
// PURPOSE
//  Six edge-triggered D flip-flops with direct set/clear, emulating an M216 FlipChip.
//  Sits directly downstream of the m617 NAND drivers. The gated pulses and levels the
//  m617 produces arrive here as clock and D inputs, and become register/control state.
//  All asynchronous DEC pulse behaviour is resampled onto the single system clock.
// PARAMETERS
//  NUM_FF     6  number of flip-flop channels
//  MIN_PULSE  2  clk cycles ck must stay high to be accepted (M216_GLITCH_FILTER_EN only, >=1)
// PORTS
//  clk     in   1        system clock; all state updates on rising edge
//  rst_n   in   1        asynchronous, active-low reset
//  d       in   NUM_FF   D data per channel
//  ck      in   NUM_FF   flip-flop clock pulse per channel (level, rising edge = clock)
//  set_l   in   NUM_FF   direct set, active low, level sensitive
//  clr_l   in   NUM_FF   direct clear, active low, level sensitive
//  q       out  NUM_FF   "1" output per channel
//  q_n     out  NUM_FF   "0" output per channel, always ~q
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): q=0, q_n=all ones; ck history=all ones; filter state cleared.
//    A ck held high across reset release never produces a clock.
//  - Channels are fully independent; the rules below apply per channel i.
//  - Edge detect: ck_prev[i] is the previous clk-sample of ck[i]. An edge is ck[i]=1 && ck_prev[i]=0.
//  - Without filter: on the clk posedge where an edge is seen, q[i] <= d[i] sampled at that posedge.
//    Latency: ck high at posedge n -> q valid after posedge n (1 cycle from pin change).
//  - Priority each posedge: clr_l=0 > set_l=0 > accepted clock > hold.
//    Both set_l and clr_l low: q=0 (clear wins). q holds after both are released.
//  - Direct set/clear held low: q is forced every cycle. Clock edges during that time are
//    discarded, not queued.
//  - A ck held high produces exactly one clock. A new clock needs ck to go low for >=1 sample.
//  - q_n is combinational ~q (no separate state), so q and q_n never agree.
// CONFIGURATION
//  M216_GLITCH_FILTER_EN defined:
//   - At the edge, d[i] is latched into a pending slot and a per-channel counter (width
//     $clog2(MIN_PULSE+1)) starts at 1. The counter increments each cycle ck stays high.
//   - When the count reaches MIN_PULSE, the pending d is committed to q[i].
//     Latency = MIN_PULSE cycles after the edge.
//   - ck low before the count reaches MIN_PULSE: pending is discarded and q is unchanged.
//   - Direct set/clear asserted while pending: pending is cancelled.
//   - MIN_PULSE=1: identical to the unfiltered build.
//  M216_GLITCH_FILTER_EN undefined: no counters or pending slots; unfiltered behaviour
//  applies and MIN_PULSE is ignored.
// TESTING
//  1 reset: rst_n=0 with ck=3F, d=3F -> q=00, q_n=3F; release rst_n, hold ck=3F 4 cycles -> q stays 00
//  2 clock: d=15, ck 00->3F for 1 cycle (no filter) -> q=15 after that posedge; d->2A with ck high -> q stays 15
//  3 direct: set_l[0]=0,clr_l[0]=0 -> q[0]=0; release set_l only -> q[0]=0; clr_l=1,set_l[0]=0 -> q[0]=1
//  4 override: clr_l[3]=0 while ck[3] rises with d[3]=1 -> q[3]=0; release clr_l, ck high -> q[3] stays 0
//  5 filter (EN, MIN_PULSE=2): d[1]=1, 1-cycle ck[1] pulse -> q[1]=0; 2-cycle pulse -> q[1]=1 two cycles after edge
//  6 async reset mid-pending (EN): edge on ck[2] with d[2]=1, rst_n=0 next cycle -> q=00, no commit after release

Source files
------------

// File: rtl/m216_ff6_if.sv
// Channel bus for the M216 six-flop FlipChip: per-channel D/clock/direct inputs and q/q_n outputs.
interface m216_ff6_if #(parameter int NUM_FF = 6);
  logic [NUM_FF-1:0] d;
  logic [NUM_FF-1:0] ck;
  logic [NUM_FF-1:0] set_l;
  logic [NUM_FF-1:0] clr_l;
  logic [NUM_FF-1:0] q;
  logic [NUM_FF-1:0] q_n;

  modport master (output d, ck, set_l, clr_l, input q, q_n);
  modport slave  (input d, ck, set_l, clr_l, output q, q_n);
endinterface

// File: rtl/m216_ff6.sv
// M216 FlipChip: NUM_FF edge-triggered D flops with direct set/clear, resampled onto clk.
// Optional build macro M216_GLITCH_FILTER_EN: ck must stay high MIN_PULSE cycles to clock.
module m216_ff6_ch #(
  parameter int MIN_PULSE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic ck,
  input  logic set_l,
  input  logic clr_l,
  output logic q
);
  logic ck_prev;
  logic ck_rise;

  assign ck_rise = ck & ~ck_prev;

`ifdef M216_GLITCH_FILTER_EN
  localparam int CW = $clog2(MIN_PULSE + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          pend_d;

  assign cnt_nx = cnt + CW'(1);

  // cnt != 0 marks a pending clock; it only survives while ck stays high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= 1'b0;
      ck_prev <= 1'b1;
      cnt     <= '0;
      pend_d  <= 1'b0;
    end else begin
      ck_prev <= ck;
      if (!clr_l) begin
        q   <= 1'b0;
        cnt <= '0;
      end else if (!set_l) begin
        q   <= 1'b1;
        cnt <= '0;
      end else if (ck_rise) begin
        if (MIN_PULSE == 1) begin
          q <= d;
        end else begin
          pend_d <= d;
          cnt    <= CW'(1);
        end
      end else if (cnt != '0) begin
        if (!ck) begin
          cnt <= '0;
        end else if (cnt_nx == CW'(MIN_PULSE)) begin
          q   <= pend_d;
          cnt <= '0;
        end else begin
          cnt <= cnt_nx;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= 1'b0;
      ck_prev <= 1'b1;
    end else begin
      ck_prev <= ck;
      if (!clr_l)       q <= 1'b0;
      else if (!set_l)  q <= 1'b1;
      else if (ck_rise) q <= d;
    end
  end
`endif
endmodule

module m216_ff6 #(
  parameter int NUM_FF    = 6,
  parameter int MIN_PULSE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  m216_ff6_if.slave     bus
);
  logic [NUM_FF-1:0] q;

  for (genvar i = 0; i < NUM_FF; i++) begin : g_ch
    m216_ff6_ch #(.MIN_PULSE(MIN_PULSE)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.d[i]),
      .ck    (bus.ck[i]),
      .set_l (bus.set_l[i]),
      .clr_l (bus.clr_l[i]),
      .q     (q[i])
    );
  end

  // q_n is derived, never stored, so it can never agree with q
  assign bus.q   = q;
  assign bus.q_n = ~q;
endmodule
